// File: rtl/atto_pkg.sv
// Shared types and width helpers for the atto AXI-Stream FIFO slice.
package atto_pkg;

  localparam int ATTO_DATA_W = 8;
  localparam int ATTO_USER_W = 1;

  // Storage layout of one beat; the RAM word packs fields in this same order.
  typedef struct packed {
    logic [ATTO_DATA_W-1:0] data;
    logic                   last;
    logic [ATTO_USER_W-1:0] user;
  } atto_beat_t;

  function automatic int atto_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int atto_beat_w(input int data_w, input int user_w);
    return data_w + 1 + user_w;
  endfunction

endpackage

// File: rtl/atto_ram_sdp.sv
// Simple dual-port beat storage: synchronous write port, asynchronous read port.
module atto_ram_sdp #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/atto_axis_fifo.sv
// AXI-Stream FIFO with 1-cycle latency; define ATTO_AXIS_FIFO_PKT_MODE_EN to
// hold m_axis_tvalid until a complete packet is stored (released when full).
module atto_axis_fifo
  import atto_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [atto_level_w(DEPTH)-1:0] level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = atto_level_w(DEPTH);
  localparam int BEAT_W = atto_beat_w(DATA_WIDTH, USER_WIDTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              run;
  logic              full, empty, push, pop;
  logic [BEAT_W-1:0] wr_beat, rd_beat;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // run holds tready low during reset and raises it on the first edge after.
  assign s_axis_tready = run & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign level         = level_q;

  assign wr_beat = {s_axis_tdata, s_axis_tlast, s_axis_tuser};
  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = rd_beat;

  atto_ram_sdp #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_beat),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef ATTO_AXIS_FIFO_PKT_MODE_EN
  logic [LVL_W-1:0] pkt_cnt;
  logic             push_last, pop_last;

  assign push_last = push & s_axis_tlast;
  assign pop_last  = pop & m_axis_tlast;

  // A full FIFO with no packet end would deadlock, so it streams regardless.
  assign m_axis_tvalid = ~empty & ((pkt_cnt != '0) | full);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + LVL_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LVL_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`else
  // level only becomes nonzero at an edge, so there is no same-cycle fall-through.
  assign m_axis_tvalid = ~empty;
`endif

endmodule

// File: tb/tb_atto_axis_fifo.sv
// Scoreboard bench for atto_axis_fifo (DEPTH=16, 8-bit data, 1-bit user).
module tb_atto_axis_fifo;
  import atto_pkg::*;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tlast = 1'b0;
  logic [0:0] s_tuser = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [0:0] m_tuser;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic [4:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  atto_beat_t exp_q[$];

  atto_axis_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(16)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .level         (level)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  atto_beat_t prev_beat;
  logic       prev_stall = 1'b0;
  always @(negedge aclk) begin
    atto_beat_t cur, e;
    cur = '{data: m_tdata, last: m_tlast, user: m_tuser};
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_tvalid), 1);
        chk("stall_beat", int'(cur), int'(prev_beat));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(cur), -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", int'(cur), int'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic l, input logic u);
    bit done;
    done = 0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        exp_q.push_back('{data: d, last: l, user: u});
        done = 1;
      end
      @(posedge aclk); #1;
    end
    if (!done) chk("push_timeout", 0, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 100 && level != 0; i++) begin
      @(posedge aclk); #1;
    end
    chk("drain_level", int'(level), 0);
    m_tready = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  logic [7:0] tog_pat;

  initial begin
    // Reset state
    #2;
    chk("rst_tready", int'(s_tready), 0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_level", int'(level), 0);
    cycles(2);
    areset = 1'b0;
    cycles(1);
    chk("post_rst_tready", int'(s_tready), 1);

`ifndef ATTO_AXIS_FIFO_PKT_MODE_EN
    // Three-beat packet with downstream always ready
    m_tready = 1'b1;
    chk("empty_tvalid", int'(m_tvalid), 0);
    push_beat(8'h11, 1'b0, 1'b0);
    chk("first_tvalid", int'(m_tvalid), 1);
    push_beat(8'h22, 1'b0, 1'b1);
    push_beat(8'h33, 1'b1, 1'b0);
    cycles(3);
    chk("pkt3_level", int'(level), 0);
    chk("pkt3_tvalid", int'(m_tvalid), 0);
    m_tready = 1'b0;
`endif

    // Fill to full, 17th beat held off until one pop
    for (int i = 0; i < 16; i++) push_beat(8'h40 + 8'(i), 1'(i == 15), 1'(i));
    chk("full_level", int'(level), 16);
    chk("full_tready", int'(s_tready), 0);
    chk("full_tvalid", int'(m_tvalid), 1);
    s_tdata = 8'h50; s_tlast = 1'b1; s_tuser = 1'b1; s_tvalid = 1'b1;
    cycles(3);
    chk("held_level", int'(level), 16);
    m_tready = 1'b1;
    cycles(1);
    m_tready = 1'b0;
    chk("pop_level", int'(level), 15);
    chk("pop_tready", int'(s_tready), 1);
    @(negedge aclk);
    if (s_tready) exp_q.push_back('{data: 8'h50, last: 1'b1, user: 1'b1});
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("refill_level", int'(level), 16);
    drain();

    // Steady push+pop at level 8 with pointer wrap
    for (int i = 0; i < 8; i++) push_beat(8'h60 + 8'(i), 1'(i == 7), 1'b0);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tdata = 8'h80 + 8'(i); s_tlast = 1'(i % 5 == 4); s_tuser = 1'(i % 3 == 0);
      @(negedge aclk);
      chk("steady_tready", int'(s_tready), 1);
      if (s_tready) exp_q.push_back('{data: s_tdata, last: s_tlast, user: s_tuser});
      @(posedge aclk); #1;
      chk("steady_level", int'(level), 8);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = 8'hC8; s_tuser = 1'b0;
    push_beat(8'hC8, 1'b1, 1'b0);
    drain();

    // Backpressure toggling on a held 0xA5 beat
    push_beat(8'hA5, 1'b0, 1'b1);
    push_beat(8'h5A, 1'b1, 1'b0);
    tog_pat = 8'b0100_1001;
    for (int i = 7; i >= 0; i--) begin
      m_tready = tog_pat[i];
      cycles(1);
    end
    m_tready = 1'b0;
    chk("toggle_level", int'(level), 0);

    // Reset mid-packet at level 5
    for (int i = 0; i < 5; i++) push_beat(8'hD0 + 8'(i), 1'b0, 1'b0);
    chk("mid_level", int'(level), 5);
    areset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_level", int'(level), 0);
    chk("arst_tvalid", int'(m_tvalid), 0);
    chk("arst_tready", int'(s_tready), 0);
    cycles(1);
    areset = 1'b0;
    @(negedge aclk);
    chk("release_tready_pre", int'(s_tready), 0);
    @(posedge aclk); #1;
    chk("release_tready", int'(s_tready), 1);
    chk("release_tvalid", int'(m_tvalid), 0);

`ifdef ATTO_AXIS_FIFO_PKT_MODE_EN
    // Packet gating, then deadlock release at full
    for (int i = 0; i < 3; i++) push_beat(8'h01 + 8'(i), 1'b0, 1'b0);
    cycles(2);
    chk("pkt_gate_tvalid", int'(m_tvalid), 0);
    push_beat(8'h04, 1'b1, 1'b0);
    chk("pkt_open_tvalid", int'(m_tvalid), 1);
    drain();
    for (int i = 0; i < 15; i++) push_beat(8'h20 + 8'(i), 1'b0, 1'b0);
    chk("pkt_15_tvalid", int'(m_tvalid), 0);
    push_beat(8'h2F, 1'b0, 1'b0);
    chk("pkt_full_tvalid", int'(m_tvalid), 1);
    m_tready = 1'b1;
    cycles(1);
    m_tready = 1'b0;
    chk("pkt_release_level", int'(level), 15);
    chk("pkt_release_tvalid", int'(m_tvalid), 0);
    push_beat(8'h30, 1'b1, 1'b1);
    drain();
`endif

    cycles(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/atto_axis_fifo.md
ATTO_AXIS_FIFO -- requirements
Module: atto_axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning tdata width in bits.
REQ-002 SHALL have parameter USER_WIDTH, default 1, meaning tuser width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning entry count; power of two, >=2.
REQ-004 SHALL have port aclk  input  1  the single clock; all logic on posedge aclk.
REQ-005 SHALL have port areset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports s_axis_tdata/tlast/tuser/tvalid  input  DATA_WIDTH/1/USER_WIDTH/1  upstream slave beat.
REQ-007 SHALL have port s_axis_tready  output  1  FIFO can accept a beat.
REQ-008 SHALL have ports m_axis_tdata/tlast/tuser/tvalid  output  DATA_WIDTH/1/USER_WIDTH/1  downstream master beat to the cb_slave consumer.
REQ-009 SHALL have port m_axis_tready  input  1  downstream accepts.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-011 SHALL push a beat {tdata,tlast,tuser} on an edge where s_axis_tvalid && s_axis_tready.
REQ-012 SHALL pop the head beat on an edge where m_axis_tvalid && m_axis_tready.
REQ-013 SHALL drive s_axis_tready = (level != DEPTH), combinationally from registered state only.
REQ-014 SHALL drive m_axis_tvalid high the cycle after the edge that makes level nonzero; no same-cycle fall-through (1-cycle latency).
REQ-015 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid && !m_axis_tready.
REQ-016 SHALL never deassert m_axis_tvalid without a pop.
REQ-017 SHALL, on simultaneous push and pop with 0<level<DEPTH, perform both and keep level unchanged.
REQ-018 SHALL, when full, refuse pushes (tready low) while still allowing a pop; pushes resume the cycle after the pop.
REQ-019 SHALL, when empty, ignore m_axis_tready and accept a push.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; level updates +1/-1/0 per edge.
REQ-021 SHALL deliver beats in push order with tlast/tuser unmodified.

Reset
REQ-022 SHALL, while areset is high, force pointers and level to 0, s_axis_tready to 0, m_axis_tvalid to 0; m_axis_tdata/tlast/tuser are don't-care.
REQ-023 SHALL assert s_axis_tready on the first posedge aclk after areset deasserts.
REQ-024 SHALL discard all stored beats on reset mid-operation, including a partially delivered packet; no memory clear required.

Configuration
REQ-025 SHALL, with ATTO_AXIS_FIFO_PKT_MODE_EN defined, assert m_axis_tvalid only when the FIFO holds at least one complete packet (a stored beat with tlast=1), tracked by a packet counter incremented on push of tlast and decremented on pop of tlast.
REQ-026 SHALL, in packet mode, additionally assert m_axis_tvalid when level == DEPTH with packet count 0 (deadlock release; beats stream until the FIFO is no longer full).
REQ-027 SHALL, without the macro, behave per REQ-014 with no packet counter synthesised.

Structure
REQ-028 SHALL place in shared package atto_pkg: typedef atto_beat_t {data, last, user} and helper constant function for level width.
REQ-029 SHALL instantiate one sub-module atto_ram_sdp (simple dual-port, sync write, async read, DEPTH x beat width); pointers/level/flags in atto_axis_fifo.

Verification
REQ-030 Push 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 -> same values out in order, first m_axis_tvalid one cycle after first push edge, tlast only on 0x33.
REQ-031 DEPTH=16, m_axis_tready=0, push 17 beats -> level=16, s_axis_tready=0 after 16th push, 17th beat held upstream; one pop -> tready=1 next cycle, 17th accepted.
REQ-032 level=8, push and pop every cycle for 40 cycles -> level stays 8, pointers wrap, data order intact.
REQ-033 Random m_axis_tready toggling on beat 0xA5 -> outputs stable until accepted, no drop/duplicate.
REQ-034 areset pulsed mid-packet with level=5 -> level=0, m_axis_tvalid=0 immediately, s_axis_tready=1 first edge after release.
REQ-035 PKT_MODE_EN: push 3 beats without tlast -> m_axis_tvalid=0; push 4th with tlast -> m_axis_tvalid=1 next cycle; 16 beats no tlast -> release at full.
